// File: rtl/rgb_pix_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : rgb_pix_fifo                                                 |
// | Description : First-word-fall-through pixel FIFO feeding the LCD timing    |
// |               stage, with occupancy count, flush and sticky underrun flag. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module rgb_pix_fifo #(
  parameter  int DW    = 24,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_rgb,
  input  logic          i_data_vld,
  output logic          o_data_ready,
  output logic [DW-1:0] o_rgb,
  output logic          o_data_vld,
  input  logic          i_data_ready,
  input  logic          i_flush,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_underrun
);

  localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_one        = (AW+1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_underrun;

  logic          w_push;
  logic          w_pop;

  // Flags derive from registered occupancy only, so ready never depends on i_data_ready.
  assign o_full       = (r_count == c_full_count);
  assign o_empty      = (r_count == '0);
  assign o_data_ready = !o_full;
  assign o_data_vld   = !o_empty;
  assign o_rgb        = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_underrun   = r_underrun;

  assign w_push = i_data_vld && o_data_ready && !i_flush;
  assign w_pop  = o_data_vld && i_data_ready && !i_flush;

  // Storage is deliberately left out of reset; o_rgb is don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rgb;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_underrun <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_one;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_one;
      end
      if (i_data_ready && o_empty) begin
        r_underrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_pix_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_rgb_pix_fifo                                              |
// | Description : Directed scoreboard bench for rgb_pix_fifo.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rgb_pix_fifo;

  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_rgb;
  logic          i_data_vld;
  logic          o_data_ready;
  logic [DW-1:0] o_rgb;
  logic          o_data_vld;
  logic          i_data_ready;
  logic          i_flush;
  logic [AW:0]   o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_underrun;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  rgb_pix_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_rgb        (i_rgb),
    .i_data_vld   (i_data_vld),
    .o_data_ready (o_data_ready),
    .o_rgb        (o_rgb),
    .o_data_vld   (o_data_vld),
    .i_data_ready (i_data_ready),
    .i_flush      (i_flush),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_underrun   (o_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: sampled mid-cycle, a pop is due at the coming edge.
  always @(negedge clk) begin
    if (o_data_vld && i_data_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: got 0x%0h, expected no pixel", o_rgb);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (o_rgb !== e) begin
          n_fail++;
          $display("FAIL scoreboard_data: got 0x%0h, expected 0x%0h", o_rgb, e);
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_rgb = '0; i_data_vld = 1'b0; i_data_ready = 1'b0; i_flush = 1'b0;
    #3;
    check("rst_count", 32'(o_count), 0);
    check("rst_empty", 32'(o_empty), 1);
    check("rst_full", 32'(o_full), 0);
    check("rst_ready", 32'(o_data_ready), 1);
    check("rst_vld", 32'(o_data_vld), 0);
    check("rst_underrun", 32'(o_underrun), 0);
    tick(); tick();
    i_rst = 1'b0;

    // Fill 16 pixels with the sink stalled.
    for (int i = 1; i <= DEPTH; i++) begin
      i_rgb = DW'(i); i_data_vld = 1'b1;
      exp_q.push_back(DW'(i));
      tick();
      if (i == 1) begin
        check("fwft_vld", 32'(o_data_vld), 1);
        check("fwft_rgb", 32'(o_rgb), 32'h1);
      end
    end
    i_data_vld = 1'b0;
    check("fill_full", 32'(o_full), 1);
    check("fill_ready", 32'(o_data_ready), 0);
    check("fill_count", 32'(o_count), 16);

    // Push attempt while full is refused.
    i_rgb = 24'hBADBAD; i_data_vld = 1'b1;
    tick();
    check("full_push_count", 32'(o_count), 16);

    // Full with simultaneous pop: only the pop happens.
    i_data_ready = 1'b1;
    tick();
    i_data_vld = 1'b0;
    check("full_pop_count", 32'(o_count), 15);
    check("full_pop_ready", 32'(o_data_ready), 1);

    for (int i = 0; i < DEPTH - 1; i++) tick();
    i_data_ready = 1'b0;
    check("drain_empty", 32'(o_empty), 1);
    check("drain_count", 32'(o_count), 0);
    check("drain_underrun", 32'(o_underrun), 0);

    // Streaming: prime one pixel, then push and pop every cycle.
    i_rgb = 24'h100000; i_data_vld = 1'b1;
    exp_q.push_back(24'h100000);
    tick();
    i_data_ready = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      i_rgb = DW'(32'h100000 + i);
      exp_q.push_back(i_rgb);
      tick();
      check("stream_count", 32'(o_count), 1);
      check("stream_rgb", 32'(o_rgb), 32'h100000 + i);
    end
    i_data_vld = 1'b0;
    tick();
    i_data_ready = 1'b0;
    check("stream_empty", 32'(o_empty), 1);
    check("stream_underrun", 32'(o_underrun), 0);

    // Underrun is sticky until flush; flush wins over a same-cycle underrun.
    i_data_ready = 1'b1;
    tick();
    i_data_ready = 1'b0;
    check("underrun_set", 32'(o_underrun), 1);
    tick(); tick(); tick();
    check("underrun_sticky", 32'(o_underrun), 1);
    i_flush = 1'b1; i_data_ready = 1'b1;
    tick();
    i_flush = 1'b0; i_data_ready = 1'b0;
    check("flush_underrun", 32'(o_underrun), 0);
    check("flush_count", 32'(o_count), 0);

    // Mid-operation asynchronous reset.
    for (int i = 0; i < 7; i++) begin
      i_rgb = DW'(32'h200000 + i); i_data_vld = 1'b1;
      exp_q.push_back(i_rgb);
      tick();
    end
    i_data_vld = 1'b0;
    check("pre_rst_count", 32'(o_count), 7);
    #2;
    i_rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_vld", 32'(o_data_vld), 0);
    check("async_rst_count", 32'(o_count), 0);
    tick();
    i_rst = 1'b0;
    i_rgb = 24'hFFFFFF; i_data_vld = 1'b1;
    exp_q.push_back(24'hFFFFFF);
    tick();
    i_data_vld = 1'b0;
    check("post_rst_rgb", 32'(o_rgb), 32'hFFFFFF);
    check("post_rst_count", 32'(o_count), 1);
    i_data_ready = 1'b1;
    tick();
    i_data_ready = 1'b0;
    check("post_rst_empty", 32'(o_empty), 1);

    // Flush versus push: the pushed pixel is discarded.
    for (int i = 0; i < 3; i++) begin
      i_rgb = DW'(32'h300000 + i); i_data_vld = 1'b1;
      tick();
    end
    check("pre_flush_count", 32'(o_count), 3);
    i_flush = 1'b1; i_rgb = 24'h00DEAD;
    tick();
    i_flush = 1'b0; i_data_vld = 1'b0;
    check("flush_push_count", 32'(o_count), 0);
    check("flush_push_empty", 32'(o_empty), 1);
    i_rgb = 24'h0ABCDE; i_data_vld = 1'b1;
    exp_q.push_back(24'h0ABCDE);
    tick();
    i_data_vld = 1'b0;
    i_data_ready = 1'b1;
    tick();
    i_data_ready = 1'b0;
    check("final_empty", 32'(o_empty), 1);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rgb_pix_fifo.md
RGB_PIX_FIFO -- requirements
Module: rgb_pix_fifo

Interface
REQ-001 Parameter DW, default 24, sets the pixel word width in bits ({b,g,r} packed as [23:16],[15:8],[7:0]).
REQ-002 Parameter DEPTH, default 16, sets the entry count; it is a power of two and at least 4.
REQ-003 Derived AW = log2(DEPTH); it is not user-settable.
REQ-004 The block has one clock and its reset is asynchronous and active-high: ports clk and i_rst.
REQ-005 Port clk: input, 1 bit, pixel clock; all state changes on its rising edge.
REQ-006 Port i_rst: input, 1 bit, asynchronous active-high reset.
REQ-007 Port i_rgb: input, DW bits, upstream pixel data.
REQ-008 Port i_data_vld: input, 1 bit, upstream pixel valid.
REQ-009 Port o_data_ready: output, 1 bit, FIFO can accept a pixel this cycle.
REQ-010 Port o_rgb: output, DW bits, head-of-FIFO pixel toward the LCD timing stage.
REQ-011 Port o_data_vld: output, 1 bit, o_rgb holds a valid pixel.
REQ-012 Port i_data_ready: input, 1 bit, downstream consumes the head pixel this cycle.
REQ-013 Port i_flush: input, 1 bit, synchronous discard of all contents and the underrun flag.
REQ-014 Port o_count: output, AW+1 bits, current occupancy, 0..DEPTH.
REQ-015 Port o_full: output, 1 bit, high when o_count == DEPTH.
REQ-016 Port o_empty: output, 1 bit, high when o_count == 0.
REQ-017 Port o_underrun: output, 1 bit, sticky flag: downstream requested data while the FIFO was empty.

Function
REQ-018 Push occurs on a cycle where i_data_vld && o_data_ready: i_rgb is written at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-019 Pop occurs on a cycle where o_data_vld && i_data_ready: rd_ptr increments modulo DEPTH.
REQ-020 o_data_ready = !o_full, combinational from registered state only, with no dependence on i_data_ready (no full-bypass).
REQ-021 o_data_vld = !o_empty; o_rgb = mem[rd_ptr] (first-word-fall-through).
REQ-022 Latency: a pixel pushed into an empty FIFO at edge N appears on o_rgb with o_data_vld=1 immediately after edge N.
REQ-023 o_count updates as follows: push-only +1; pop-only -1; simultaneous push and pop unchanged; neither unchanged.
REQ-024 When full, a push is impossible; a pop alone drops o_count to DEPTH-1 and raises o_data_ready on the next cycle.
REQ-025 When empty, a pop is impossible; a push alone raises o_count to 1.
REQ-026 Simultaneous push and pop at o_count == 1: output advances to the new pixel; o_count stays 1; o_data_vld stays high.
REQ-027 Pointer wrap: pointers are AW bits and wrap from DEPTH-1 to 0 with no gap; data order is strictly preserved across wrap.
REQ-028 o_underrun is set at the edge where i_data_ready=1 and o_empty=1; it stays set until i_flush or i_rst.
REQ-029 When i_flush=1 at an edge: wr_ptr, rd_ptr, and o_count go to 0, o_underrun goes to 0, and any same-cycle push or pop is ignored.
REQ-030 i_flush has priority over the underrun set condition in the same cycle.
REQ-031 Memory contents are not reset; o_rgb is don't-care while o_data_vld=0.

Reset
REQ-032 While i_rst=1: wr_ptr=0, rd_ptr=0, o_count=0, o_empty=1, o_full=0, o_data_ready=1, o_data_vld=0, o_underrun=0.
REQ-033 Assertion of i_rst mid-operation discards all stored pixels immediately, without waiting for a clock edge.
REQ-034 Release of i_rst is synchronised by the integrator; the block accepts a push on the first edge after release.

Verification
REQ-035 Fill/drain: push 16 pixels 0x000001..0x000010 with i_data_ready=0 -> o_full=1, o_data_ready=0, o_count=16; then hold i_data_ready=1 -> o_rgb reads 0x000001..0x000010 in order, then o_empty=1.
REQ-036 Streaming: hold i_data_vld=1 and i_data_ready=1 continuously for 40 pixels -> o_count stays 1, output equals input delayed one cycle, and wrap is crossed twice without error.
REQ-037 Full with simultaneous pop: at o_count=16 with i_data_vld=1 and i_data_ready=1 -> no push that cycle, o_count=15, and o_data_ready=1 next cycle.
REQ-038 Underrun: with the FIFO empty, drive i_data_ready=1 for one cycle -> o_underrun=1 and it stays set; a later i_flush pulse -> o_underrun=0 and o_count=0.
REQ-039 Mid-operation reset: with o_count=7, assert i_rst between edges -> o_data_vld=0 and o_count=0 before the next edge; after release, push 0xFFFFFF -> o_rgb=0xFFFFFF and o_count=1.
REQ-040 Flush versus push: at o_count=3, drive i_flush=1 with i_data_vld=1 in the same cycle -> o_count=0 and o_empty=1; the pushed pixel is discarded.
